// File: rtl/uart_tx_design.sv
// UART transmitter: byte FIFO feeding an 8N1/8E1 framing FSM with a built-in baud divider.
// The serial line and all status flags come straight from registers.
module uart_tx_design #(
  parameter int CLKS_PER_BIT = 7,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] d_in,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          parity_bit, parity_next;
  logic          tx_next, push, pop, bit_done;

  assign push     = wr_en && !tx_full;
  assign bit_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next  = state;
    baud_next   = bit_done ? '0 : baud_cnt + 1'b1;
    bit_next    = bit_idx;
    shift_next  = shift;
    parity_next = parity_bit;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!tx_empty) begin
          pop         = 1'b1;
          state_next  = START;
          shift_next  = mem[rd_ptr];
          parity_next = ^mem[rd_ptr];
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next = {1'b0, shift[7:1]};
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (bit_done) begin
          if (!tx_empty) begin
            pop         = 1'b1;
            state_next  = START;
            shift_next  = mem[rd_ptr];
            parity_next = ^mem[rd_ptr];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase

    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_full    <= 1'b0;
      tx_empty   <= 1'b1;
      tx_busy    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_next;
      shift      <= shift_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      count      <= count_next;
      tx_full    <= (count_next == (AW+1)'(FIFO_DEPTH));
      tx_empty   <= (count_next == '0);
      tx_busy    <= (state_next != IDLE);
      overflow   <= wr_en && tx_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_design.sv
// Bench for uart_tx_design: directed steps, scoreboard queues of expected bytes,
// and a line-level receiver model per instance (8N1 and 8E1).
module tb_uart_tx_design;

  localparam int CPB = 7;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr0 = 1'b0, wr1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       tx0, full0, empty0, busy0, ovf0;
  logic       tx1, full1, empty1, busy1, ovf1;

  int n_tests = 0;
  int n_fail  = 0;
  int b0_run = 0, b1_run = 0, b0_ovf = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  uart_tx_design #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .PARITY_EN(0)) u0 (
    .clk(clk), .reset(rst), .wr_en(wr0), .d_in(d0), .tx(tx0),
    .tx_full(full0), .tx_empty(empty0), .tx_busy(busy0), .overflow(ovf0));

  uart_tx_design #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(rst), .wr_en(wr1), .d_in(d1), .tx(tx1),
    .tx_full(full1), .tx_empty(empty1), .tx_busy(busy1), .overflow(ovf1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle0(input int bound);
    int k = 0;
    while (busy0 === 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check("idle0_reached", {31'd0, busy0}, 32'd0);
  endtask

  task automatic wait_idle1(input int bound);
    int k = 0;
    while (busy1 === 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check("idle1_reached", {31'd0, busy1}, 32'd0);
  endtask

  // Background counters sampled mid-cycle, away from the main flow's sample point.
  initial forever begin
    @(posedge clk);
    #2;
    if (busy0 === 1'b1) b0_run++;
    if (busy1 === 1'b1) b1_run++;
    if (ovf0 === 1'b1) b0_ovf++;
  end

  // Receiver model for the 8N1 instance.
  initial begin
    int   cnt;
    bit   act;
    logic [7:0] by;
    logic [7:0] exp;
    act = 0; cnt = 0; by = '0;
    forever begin
      @(negedge clk);
      if (!rst) act = 0;
      else if (!act) begin
        if (tx0 === 1'b0) begin act = 1; cnt = 0; end
      end else cnt++;
      if (act && rst) begin
        if (cnt == HALF) check("rx0_start", {31'd0, tx0}, 32'd0);
        for (int j = 0; j < 8; j++)
          if (cnt == (1 + j) * CPB + HALF) by[j] = tx0;
        if (cnt == 9 * CPB + HALF) check("rx0_stop", {31'd0, tx0}, 32'd1);
        if (cnt == 10 * CPB - 1) begin
          act = 0;
          check("rx0_frame_expected", {31'd0, q0.size() != 0}, 32'd1);
          if (q0.size() != 0) begin
            exp = q0.pop_front();
            check("rx0_byte", {24'd0, by}, {24'd0, exp});
          end
        end
      end
    end
  end

  // Receiver model for the 8E1 instance.
  initial begin
    int   cnt;
    bit   act;
    logic [7:0] by;
    logic [7:0] exp;
    logic par;
    act = 0; cnt = 0; by = '0; par = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) act = 0;
      else if (!act) begin
        if (tx1 === 1'b0) begin act = 1; cnt = 0; end
      end else cnt++;
      if (act && rst) begin
        if (cnt == HALF) check("rx1_start", {31'd0, tx1}, 32'd0);
        for (int j = 0; j < 8; j++)
          if (cnt == (1 + j) * CPB + HALF) by[j] = tx1;
        if (cnt == 9 * CPB + HALF) par = tx1;
        if (cnt == 10 * CPB + HALF) check("rx1_stop", {31'd0, tx1}, 32'd1);
        if (cnt == 11 * CPB - 1) begin
          act = 0;
          check("rx1_frame_expected", {31'd0, q1.size() != 0}, 32'd1);
          if (q1.size() != 0) begin
            exp = q1.pop_front();
            check("rx1_byte", {24'd0, by}, {24'd0, exp});
            check("rx1_parity", {31'd0, par}, {31'd0, ^exp});
          end
        end
      end
    end
  end

  initial begin
    int lowc;
    int i;
    int k;
    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst_tx", {31'd0, tx0}, 32'd1);
    check("rst_full", {31'd0, full0}, 32'd0);
    check("rst_empty", {31'd0, empty0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_overflow", {31'd0, ovf0}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Single byte 0xA5.
    b0_run = 0;
    wr0 = 1'b1; d0 = 8'hA5; q0.push_back(8'hA5);
    tick();
    wr0 = 1'b0;
    check("single_empty_after_write", {31'd0, empty0}, 32'd0);
    check("single_tx_still_high", {31'd0, tx0}, 32'd1);
    tick();
    check("single_tx_start", {31'd0, tx0}, 32'd0);
    check("single_busy", {31'd0, busy0}, 32'd1);
    check("single_empty_after_pop", {31'd0, empty0}, 32'd1);
    wait_idle0(200);
    check("single_busy_cycles", b0_run, 32'd70);
    check("single_decoded", q0.size(), 32'd0);
    repeat (3) tick();

    // Back-to-back frames.
    b0_run = 0;
    wr0 = 1'b1; d0 = 8'h00; q0.push_back(8'h00);
    tick();
    d0 = 8'hFF; q0.push_back(8'hFF);
    tick();
    d0 = 8'h3C; q0.push_back(8'h3C);
    tick();
    wr0 = 1'b0;
    wait_idle0(400);
    check("b2b_busy_cycles", b0_run, 32'd210);
    check("b2b_decoded", q0.size(), 32'd0);
    repeat (3) tick();

    // Full / overflow: ten writes, first is popped, nine accepted, tenth dropped.
    b0_run = 0; b0_ovf = 0;
    for (int n = 0; n < 10; n++) begin
      wr0 = 1'b1; d0 = 8'h40 + 8'(n);
      if (n < 9) q0.push_back(8'h40 + 8'(n));
      tick();
      if (n == 8) check("full_set", {31'd0, full0}, 32'd1);
      if (n == 9) check("overflow_pulse", {31'd0, ovf0}, 32'd1);
    end
    wr0 = 1'b0;
    tick();
    check("overflow_one_cycle", {31'd0, ovf0}, 32'd0);
    wait_idle0(800);
    check("full_overflow_count", b0_ovf, 32'd1);
    check("full_busy_cycles", b0_run, 32'd630);
    check("full_decoded", q0.size(), 32'd0);
    repeat (3) tick();

    // Even parity instance.
    b1_run = 0;
    wr1 = 1'b1; d1 = 8'h07; q1.push_back(8'h07);
    tick();
    d1 = 8'h03; q1.push_back(8'h03);
    tick();
    wr1 = 1'b0;
    wait_idle1(300);
    check("parity_busy_cycles", b1_run, 32'd154);
    check("parity_decoded", q1.size(), 32'd0);
    repeat (3) tick();

    // Reset during DATA bit 3 with two bytes still queued.
    wr0 = 1'b1; d0 = 8'h5A;
    tick();
    d0 = 8'h11;
    tick();
    d0 = 8'h22;
    tick();
    wr0 = 1'b0;
    repeat (27) tick();
    #3 rst = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx0}, 32'd1);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_empty", {31'd0, empty0}, 32'd1);
    check("abort_full", {31'd0, full0}, 32'd0);
    q0.delete();
    @(posedge clk);
    #4 rst = 1'b1;
    b0_run = 0; lowc = 0;
    for (int n = 0; n < 150; n++) begin
      tick();
      if (tx0 !== 1'b1) lowc++;
    end
    check("abort_no_frame_tx", lowc, 32'd0);
    check("abort_no_busy", b0_run, 32'd0);

    // Wrap-around stream of 20 bytes, writing only when not full.
    b0_ovf = 0; i = 0; k = 0;
    while (i < 20 && k < 3000) begin
      if (full0 === 1'b0) begin
        wr0 = 1'b1; d0 = 8'(i); q0.push_back(8'(i));
        i++;
      end else begin
        wr0 = 1'b0;
      end
      tick();
      k++;
    end
    wr0 = 1'b0;
    check("wrap_all_written", i, 32'd20);
    wait_idle0(1600);
    check("wrap_decoded", q0.size(), 32'd0);
    check("wrap_no_overflow", b0_ovf, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
